sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Two-requester controller for the 128 x 32 single-port SRAM. Sequences a power-up clear of the whole array, then shares the single SRAM port between two requesters (requester 0 and requester 1, e.g. fetch and load/store) with round-robin arbitration. Every access, read or write, uses a valid/ready request handshake and returns a valid/ready response. The block drives all SRAM control pins: `cs`, `we`, `addr`, `data_in`.

## Interface
Parameters:
- `ADDR_W`, 7: SRAM address width (depth 2^ADDR_W = 128).
- `DATA_W`, 32: data width.
- `CLEAR_ON_RESET`, 1: 1 = zero-fill the array after reset; 0 = go straight to IDLE.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `reqN_valid`  in  1  requester N (N = 0, 1) has a command.
- `reqN_ready`  out  1  command accepted this cycle.
- `reqN_we`  in  1  1 = write, 0 = read.
- `reqN_addr`  in  ADDR_W  word address.
- `reqN_wdata`  in  DATA_W  write data.
- `rspN_valid`  out  1  response for requester N available.
- `rspN_data`  out  DATA_W  read data; 0 for write acknowledgements.
- `rspN_ready`  in  1  requester N consumes the response.
- `mem_cs`  out  1  SRAM chip select.
- `mem_we`  out  1  SRAM write enable.
- `mem_addr`  out  ADDR_W  SRAM address.
- `mem_wdata`  out  DATA_W  SRAM data_in.
- `mem_rdata`  in  DATA_W  SRAM data_out; combinational read, valid in the same cycle as `mem_cs`/`mem_addr`.
- `busy`  out  1  high while the clear sequence runs.

## Operation
- **States:** INIT, IDLE, ACCESS, RESP.
- **Reset values:**
  - `mem_cs`, `mem_we`, `mem_addr`, `mem_wdata` = 0.
  - `reqN_ready` = 0; `rspN_valid` = 0; `rspN_data` = 0.
  - `busy` = CLEAR_ON_RESET; priority pointer = 0.
  - State = INIT if CLEAR_ON_RESET, else IDLE.
- **INIT:**
  - Clear counter runs 0..127.
  - Each cycle drives `mem_cs`=1, `mem_we`=1, `mem_addr`=counter, `mem_wdata`=0.
  - After address 127 is written: state goes to IDLE and `busy` goes to 0.
  - `reqN_ready` = 0 throughout.
- **IDLE:**
  - Grant is combinational. If only one `reqN_valid` is high, it is granted. If both are high, the requester named by the priority pointer is granted.
  - `ready` is asserted to the granted requester only.
  - On the accept edge: latch we, addr and wdata into the command register, record the grant owner, and set pointer = the other requester.
  - Next state: ACCESS.
- **ACCESS (one cycle):**
  - Drive `mem_cs`=1, `mem_we`=cmd_we, `mem_addr`, `mem_wdata` from the command register.
  - On a read, capture `mem_rdata` at the end of the cycle.
  - Next state: RESP.
- **RESP:**
  - `rspN_valid`=1 for the owner only.
  - `rspN_data` = captured data for a read, 0 for a write.
  - Hold valid and data stable until `rspN_ready`=1, then go to IDLE.
  - No new request is accepted while in RESP.
- `mem_cs` and `mem_we` are 0 in IDLE and RESP.
- **Requester rule:** `reqN_*` must be held stable while `reqN_valid`=1 and `reqN_ready`=0. A non-granted requester simply waits.
- **Mid-operation reset:** an in-flight command and any pending response are dropped (`rsp_valid` goes to 0). The pointer returns to 0 and the clear restarts from address 0.

## Timing
- Request accepted at edge T (valid & ready at cycle T).
- ACCESS occupies cycle T+1.
- `rspN_valid` asserts in cycle T+2.
- If `rspN_ready`=1 in T+2, IDLE is in T+3 and the next accept can happen in T+3.
- Maximum throughput: one access per 3 cycles. A stalled response extends RESP one cycle per stall cycle.
- **Clear sequence:** with reset deasserted before edge 0, clear writes occupy cycles 1..128. IDLE and `busy`=0 in cycle 129; first accept can happen in cycle 129.
- **Fairness:** with both requesters continuously valid, grants strictly alternate 0,1,0,1,..., starting with 0 after reset.
- **Read-after-write:** a read issued after a completed write returns the new data. Order is guaranteed by the single outstanding command.

## Test plan
- **Reset clear:** CLEAR_ON_RESET=1, release `rst`. Required: exactly 128 cycles with `mem_cs`=`mem_we`=1, addresses 0..127 in order, `mem_wdata`=0. Then `busy`=0 and no `reqN_ready` asserted before that point.
- **Single write then read:** req0 writes 0xDEADBEEF to address 0x05, then req0 reads 0x05. Required: write ack `rsp0_data`=0 at T+2. The read returns 0xDEADBEEF at T+2 of its own accept.
- **Contention:** both requesters valid every cycle; req0 reads 0x10, req1 reads 0x20, `rsp_ready` always 1. Required: grants alternate 0,1,0,1, each access 3 cycles apart, and `rsp1_valid` never asserts for a req0 command.
- **Response backpressure:** read 0x7F with `rsp1_ready` held low for 5 cycles. Required: `rsp1_valid` and `rsp1_data` stay stable all 5 cycles, no `reqN_ready` asserts meanwhile, and IDLE follows the cycle after `rsp1_ready`=1.
- **Reset mid-access:** assert `rst` in an ACCESS cycle. Required: `rspN_valid`=0, the clear restarts at address 0, and the pointer resets so that req0 wins the first contended grant.
- **Address wrap:** write address 0x7F and address 0x00 with distinct data, then read both back. Required: each read returns its own data.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Controller for a single-port 2^ADDR_W x DATA_W SRAM shared by two
//   requesters. After reset it optionally zero-fills the whole array. It then
//   arbitrates round-robin between requester 0 and requester 1, one
//   outstanding command at a time: IDLE (accept) -> ACCESS (SRAM cycle) ->
//   RESP (hold response until consumed).
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/ready          command handshake for requester N (0, 1)
//   reqN_we/addr/wdata        command: write flag, word address, write data
//   rspN_valid/ready/data     response handshake; data is 0 for write acks
//   mem_cs/we/addr/wdata      SRAM control and write data (registered)
//   mem_rdata                 SRAM read data, combinational from mem_addr
//   busy                      high while the power-up clear runs
module sram_port_arbiter #(
    parameter int ADDR_W         = 7,
    parameter int DATA_W         = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              rsp0_ready,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    input  logic              rsp1_ready,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {INIT, IDLE, ACCESS, RESP} state_t;

    state_t            state;
    logic [ADDR_W:0]   clr_cnt;   // extra MSB flags "all addresses written"
    logic              ptr;       // requester that wins a tie
    logic              owner;     // requester of the in-flight command
    logic              grant;     // requester selected this cycle
    logic              any_req;
    logic              rsp_take;

    // Grant: a lone requester wins; on a tie the priority pointer decides.
    always_comb begin
        any_req = req0_valid | req1_valid;
        grant   = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ptr;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        req0_ready = (state == IDLE) && !rst && req0_valid && !grant;
        req1_ready = (state == IDLE) && !rst && req1_valid && grant;
        rsp_take   = owner ? rsp1_ready : rsp0_ready;
    end

    // The registered mem_we/mem_addr/mem_wdata double as the command
    // register: they are loaded on the accept edge and drive the SRAM
    // directly during ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR_ON_RESET ? INIT : IDLE;
            busy       <= CLEAR_ON_RESET;
            clr_cnt    <= '0;
            ptr        <= 1'b0;
            owner      <= 1'b0;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (clr_cnt[ADDR_W]) begin
                        mem_cs <= 1'b0;
                        mem_we <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        mem_cs    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= clr_cnt[ADDR_W-1:0];
                        mem_wdata <= '0;
                        clr_cnt   <= clr_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (any_req) begin
                        owner     <= grant;
                        ptr       <= ~grant;
                        mem_cs    <= 1'b1;
                        mem_we    <= grant ? req1_we    : req0_we;
                        mem_addr  <= grant ? req1_addr  : req0_addr;
                        mem_wdata <= grant ? req1_wdata : req0_wdata;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_cs <= 1'b0;
                    mem_we <= 1'b0;
                    if (owner) begin
                        rsp1_valid <= 1'b1;
                        rsp1_data  <= mem_we ? '0 : mem_rdata;
                    end else begin
                        rsp0_valid <= 1'b1;
                        rsp0_data  <= mem_we ? '0 : mem_rdata;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_take) begin
                        rsp0_valid <= 1'b0;
                        rsp0_data  <= '0;
                        rsp1_valid <= 1'b0;
                        rsp1_data  <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//   Self-checking bench for sram_port_arbiter. Contains a behavioural SRAM,
//   a word-array reference of the expected memory contents, a table of
//   directed transactions, hand-written contention / backpressure / reset
//   sequences and a randomized phase checked against the reference.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_we;
    logic [6:0]  req0_addr;
    logic [31:0] req0_wdata;
    logic        rsp0_valid, rsp0_ready;
    logic [31:0] rsp0_data;
    logic        req1_valid, req1_ready, req1_we;
    logic [6:0]  req1_addr;
    logic [31:0] req1_wdata;
    logic        rsp1_valid, rsp1_ready;
    logic [31:0] rsp1_data;
    logic        mem_cs, mem_we;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        busy;

    int errors = 0;
    int checks = 0;

    sram_port_arbiter #(.ADDR_W(7), .DATA_W(32), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural 128 x 32 SRAM: synchronous write, combinational read.
    logic [31:0] sram [128];
    always @(posedge clk) if (mem_cs && mem_we) sram[mem_addr] <= mem_wdata;
    assign mem_rdata = sram[mem_addr];

    // Reference: expected array contents and the requester that wins a tie.
    logic [31:0] model [128];
    int          exp_ptr;

    typedef struct {
        int          r;
        bit          we;
        logic [6:0]  addr;
        logic [31:0] wdata;
        int          stall;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(input int r, input bit v, input bit we,
                           input logic [6:0] a, input logic [31:0] d);
        if (r == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 128; i++) model[i] = '0;
        exp_ptr = 0;
    endtask

    // One complete transaction starting at a negedge in an IDLE cycle and
    // ending at the negedge of the following IDLE cycle.
    task automatic txn(input int r, input bit we, input logic [6:0] a,
                       input logic [31:0] d, input int stall,
                       input logic [31:0] exp, input string nm);
        logic [1:0] own;
        own = (r == 1) ? 2'b10 : 2'b01;
        set_req(r, 1'b1, we, a, d);
        if (r == 0) rsp0_ready = (stall == 0); else rsp1_ready = (stall == 0);
        #1;
        chk({nm, "_ready"}, {req1_ready, req0_ready}, {30'd0, own});
        @(posedge clk); #1;
        set_req(r, 1'b0, 1'b0, '0, '0);
        exp_ptr = 1 - r;
        @(negedge clk);  // ACCESS
        chk({nm, "_cs"},   mem_cs, 1'b1);
        chk({nm, "_we"},   mem_we, we);
        chk({nm, "_addr"}, mem_addr, a);
        if (we) chk({nm, "_wdata"}, mem_wdata, d);
        chk({nm, "_norsp"}, {rsp1_valid, rsp0_valid}, 2'b00);
        @(negedge clk);  // RESP, first cycle
        chk({nm, "_rspv"}, {rsp1_valid, rsp0_valid}, own);
        chk({nm, "_data"}, (r == 1) ? rsp1_data : rsp0_data, exp);
        chk({nm, "_cs_resp"}, mem_cs, 1'b0);
        if (stall > 0) begin
            set_req(1 - r, 1'b1, 1'b0, 7'h00, '0);
            for (int s = 1; s <= stall; s++) begin
                @(negedge clk);
                chk({nm, "_stall_v"}, {rsp1_valid, rsp0_valid}, own);
                chk({nm, "_stall_d"}, (r == 1) ? rsp1_data : rsp0_data, exp);
                chk({nm, "_stall_rdy"}, {req1_ready, req0_ready}, 2'b00);
            end
            set_req(1 - r, 1'b0, 1'b0, '0, '0);
            if (r == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        end
        @(negedge clk);  // IDLE
        chk({nm, "_done"}, {rsp1_valid, rsp0_valid}, 2'b00);
        if (we) model[a] = d;
    endtask

    initial begin
        int g, gcount, last_cyc, exp_r, owner;
        logic [1:0] rp;

        tbl[0] = '{0, 1'b1, 7'h05, 32'hDEADBEEF, 0, 32'h0,        "wr05"};
        tbl[1] = '{0, 1'b0, 7'h05, 32'h0,        0, 32'hDEADBEEF, "rd05"};
        tbl[2] = '{1, 1'b1, 7'h7F, 32'h11111111, 0, 32'h0,        "wr7f"};
        tbl[3] = '{0, 1'b1, 7'h00, 32'h22222222, 0, 32'h0,        "wr00"};
        tbl[4] = '{1, 1'b0, 7'h7F, 32'h0,        0, 32'h11111111, "rd7f"};
        tbl[5] = '{0, 1'b0, 7'h00, 32'h0,        0, 32'h22222222, "rd00"};
        tbl[6] = '{1, 1'b0, 7'h7F, 32'h0,        5, 32'h11111111, "rd7f_bp"};
        tbl[7] = '{0, 1'b1, 7'h10, 32'hA5A50010, 0, 32'h0,        "wr10"};
        tbl[8] = '{1, 1'b1, 7'h20, 32'h5A5A0020, 0, 32'h0,        "wr20"};

        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        clear_model();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cs", {mem_cs, mem_we}, 2'b00);
        chk("rst_addr", mem_addr, 7'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_rspv", {rsp1_valid, rsp0_valid}, 2'b00);
        chk("rst_rspd", rsp0_data | rsp1_data, 32'h0);
        chk("rst_busy", busy, 1'b1);

        // Power-up clear: 128 writes, no ready even with a pending request
        rst = 1'b0;
        req0_valid = 1'b1;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            chk("clr_cswe", {mem_cs, mem_we}, 2'b11);
            chk("clr_addr", mem_addr, i[6:0]);
            chk("clr_wdata", mem_wdata, 32'h0);
            chk("clr_busy", busy, 1'b1);
            chk("clr_ready", {req1_ready, req0_ready}, 2'b00);
        end
        req0_valid = 1'b0;
        @(negedge clk);
        chk("clr_done_busy", busy, 1'b0);
        chk("clr_done_cs", mem_cs, 1'b0);

        // Directed table
        for (int i = 0; i < 9; i++)
            txn(tbl[i].r, tbl[i].we, tbl[i].addr, tbl[i].wdata,
                tbl[i].stall, tbl[i].exp, tbl[i].name);

        // Contention: both always valid, rsp_ready always 1
        set_req(0, 1'b1, 1'b0, 7'h10, '0);
        set_req(1, 1'b1, 1'b0, 7'h20, '0);
        gcount = 0; last_cyc = -1; exp_r = exp_ptr; owner = 0;
        for (int cyc = 0; cyc < 18; cyc++) begin
            #1;
            if (req0_ready || req1_ready) begin
                chk("cont_single_grant", {req1_ready, req0_ready} != 2'b11, 1'b1);
                g = req1_ready ? 1 : 0;
                chk("cont_order", g, exp_r);
                if (last_cyc >= 0) chk("cont_spacing", cyc - last_cyc, 3);
                last_cyc = cyc; exp_r = 1 - exp_r; owner = g; gcount++;
            end
            rp = {rsp1_valid, rsp0_valid};
            if (rp != 2'b00) begin
                chk("cont_rsp_owner", rp, (owner == 1) ? 2'b10 : 2'b01);
                chk("cont_rsp_data", (owner == 1) ? rsp1_data : rsp0_data,
                    (owner == 1) ? model[7'h20] : model[7'h10]);
            end
            @(negedge clk);
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        chk("cont_grants", gcount, 6);
        exp_ptr = exp_r;

        // Reset during ACCESS after a req0 grant (pointer then favours req1)
        set_req(0, 1'b1, 1'b0, 7'h10, '0);
        #1 chk("mid_ready", req0_ready, 1'b1);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("mid_access_cs", mem_cs, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rspv", {rsp1_valid, rsp0_valid}, 2'b00);
        chk("mid_busy", busy, 1'b1);
        chk("mid_cs", mem_cs, 1'b0);
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        chk("mid_clr0", {mem_cs, mem_we, 25'd0, mem_addr}, {2'b11, 25'd0, 7'h00});
        @(negedge clk);
        chk("mid_clr1", mem_addr, 7'h01);
        for (int i = 0; i < 300 && busy; i++) @(negedge clk);
        chk("mid_clr_done", busy, 1'b0);
        set_req(0, 1'b1, 1'b0, 7'h10, '0);
        set_req(1, 1'b1, 1'b0, 7'h20, '0);
        #1 chk("mid_first_grant", {req1_ready, req0_ready}, 2'b01);
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        chk("mid_rsp0", {rsp1_valid, rsp0_valid}, 2'b01);
        chk("mid_rsp0_data", rsp0_data, 32'h0);
        @(negedge clk);
        #1 chk("mid_second_grant", {req1_ready, req0_ready}, 2'b10);
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        chk("mid_idle", {rsp1_valid, rsp0_valid, mem_cs}, 3'b000);

        // Randomized single-requester traffic against the reference array
        for (int i = 0; i < 40; i++) begin
            int          r, st, sel;
            bit          we;
            logic [6:0]  a;
            logic [31:0] d;
            r   = $urandom_range(0, 1);
            we  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 3);
            a   = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h01 : (sel == 2) ? 7'h7F : 7'h40;
            d   = $urandom;
            st  = $urandom_range(0, 2);
            txn(r, we, a, d, st, we ? 32'h0 : model[a], "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
